// File: rtl/anim_pkg.sv
// Shared animation definitions for the player animation producer and the
// sprite fetch consumer: state encodings, sprite geometry and colour key.
package anim_pkg;

  localparam int STATE_W          = 4;
  localparam int SPR_W            = 32;
  localparam int SPR_H            = 32;
  localparam int FRAMES_PER_STATE = 4;

  localparam int COL_W  = $clog2(SPR_W);
  localparam int ROW_W  = $clog2(SPR_H);
  localparam int FIDX_W = $clog2(FRAMES_PER_STATE);

  localparam logic [7:0] KEY_COLOR = 8'hE3;

  localparam logic [STATE_W-1:0] S_IDLE = 4'd0;
  localparam logic [STATE_W-1:0] S_WALK = 4'd1;
  localparam logic [STATE_W-1:0] S_JUMP = 4'd2;
  localparam logic [STATE_W-1:0] S_ATK1 = 4'd3;
  localparam logic [STATE_W-1:0] S_ATK2 = 4'd4;
  localparam logic [STATE_W-1:0] S_HIT  = 4'd5;
  localparam logic [STATE_W-1:0] S_LOSE = 4'd6;

  // True for encodings that have artwork stored in the sprite ROM.
  function automatic logic is_known_state(input logic [STATE_W-1:0] st);
    return st <= S_LOSE;
  endfunction

endpackage

// File: rtl/anim_frame_seq.sv
// Effective animation frame generator. The producer always reports frame 0
// while walking, so the walk cycle is stepped here on the game tick. Unknown
// states fall back to IDLE frame 0, HIT always shows frame 0, and any other
// frame number beyond the stored frames is clamped to the last one.
module anim_frame_seq
  import anim_pkg::*;
#(
  parameter int WALK_HOLD = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scen,
  input  logic [STATE_W-1:0] anim_state,
  input  logic [5:0]         anim_frame,
  output logic [STATE_W-1:0] eff_state,
  output logic [FIDX_W-1:0]  eff_frame
);

  localparam int HOLD_W = (WALK_HOLD > 1) ? $clog2(WALK_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic [FIDX_W-1:0] walk_idx;

  // Walk cycle: hold each frame for WALK_HOLD ticks, restart whenever the
  // player leaves WALK so every new walk begins on frame 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      walk_idx <= '0;
    end else if (scen) begin
      if (anim_state == S_WALK) begin
        if (hold_cnt == HOLD_W'(WALK_HOLD - 1)) begin
          hold_cnt <= '0;
          walk_idx <= walk_idx + 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
        walk_idx <= '0;
      end
    end
  end

  // Sanitise the producer's state/frame into something the ROM can serve.
  always_comb begin
    eff_state = anim_state;
    eff_frame = '0;
    if (!is_known_state(anim_state)) begin
      eff_state = S_IDLE;
      eff_frame = '0;
    end else if (anim_state == S_WALK) begin
      eff_frame = walk_idx;
    end else if (anim_state == S_HIT) begin
      eff_frame = '0;
    end else if (anim_frame > 6'(FRAMES_PER_STATE - 1)) begin
      eff_frame = FIDX_W'(FRAMES_PER_STATE - 1);
    end else begin
      eff_frame = anim_frame[FIDX_W-1:0];
    end
  end

endmodule

// File: rtl/player_sprite_fetch.sv
// Player sprite fetch: snapshots the animation at each video frame start,
// turns the current scan position into a sprite-ROM address (with optional
// horizontal mirroring) and qualifies the returned pixel against the colour
// key. Outputs follow the scan position by two clocks; the second stage is
// a registered in-box flag aligned with the synchronous ROM's read data.
// Optional: define HIT_FLASH_EN to blink the HIT sprite 4 frames on / 4 off.
module player_sprite_fetch
  import anim_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int COLOR_W   = 8,
  parameter int WALK_HOLD = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               SCEN,
  input  logic               frame_start,
  input  logic [3:0]         anim_state,
  input  logic [5:0]         anim_frame,
  input  logic               facing_left,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               video_on,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid
);

  logic [STATE_W-1:0] eff_state;
  logic [FIDX_W-1:0]  eff_frame;

  logic [STATE_W-1:0] snap_state;
  logic [FIDX_W-1:0]  snap_frame;
  logic [9:0]         snap_px;
  logic [9:0]         snap_py;
  logic               snap_facing;
  logic               armed;

  logic [10:0]        col_full;
  logic [10:0]        row_full;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   mcol;
  logic               in_box;
  logic [ADDR_W-1:0]  addr_next;

  logic               in_box_d1;
  logic               in_box_d2;
  logic               flash_blank;
  logic               opaque;

  anim_frame_seq #(
    .WALK_HOLD (WALK_HOLD)
  ) u_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .scen       (SCEN),
    .anim_state (anim_state),
    .anim_frame (anim_frame),
    .eff_state  (eff_state),
    .eff_frame  (eff_frame)
  );

  // Freeze the animation for a whole video frame so the sprite never tears;
  // drawing stays disabled after reset until the first frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_state  <= '0;
      snap_frame  <= '0;
      snap_px     <= '0;
      snap_py     <= '0;
      snap_facing <= 1'b0;
      armed       <= 1'b0;
    end else if (frame_start) begin
      snap_state  <= eff_state;
      snap_frame  <= eff_frame;
      snap_px     <= pos_x;
      snap_py     <= pos_y;
      snap_facing <= facing_left;
      armed       <= 1'b1;
    end
  end

  // Box test done one bit wider than the screen so a sprite hanging off
  // the right or bottom edge clips instead of wrapping to the other side.
  always_comb begin
    col_full  = {1'b0, hcount} - {1'b0, snap_px};
    row_full  = {1'b0, vcount} - {1'b0, snap_py};
    in_box    = video_on
                && !col_full[10] && (col_full < 11'(SPR_W))
                && !row_full[10] && (row_full < 11'(SPR_H));
    col       = col_full[COL_W-1:0];
    row       = row_full[ROW_W-1:0];
    mcol      = snap_facing ? (COL_W'(SPR_W - 1) - col) : col;
    addr_next = (ADDR_W'(snap_state) << (FIDX_W + ROW_W + COL_W))
              | (ADDR_W'(snap_frame) << (ROW_W + COL_W))
              | (ADDR_W'(row)        << COL_W)
              | ADDR_W'(mcol);
  end

  // Address stage and the in-box flag pipeline that tracks the ROM read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
    end else begin
      rom_addr  <= in_box ? addr_next : '0;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
    end
  end

`ifdef HIT_FLASH_EN
  logic [2:0] flash_cnt;

  // Free-running frame counter; its top bit blanks the HIT sprite.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt <= '0;
    end else if (frame_start) begin
      flash_cnt <= flash_cnt + 3'd1;
    end
  end

  assign flash_blank = (snap_state == S_HIT) && flash_cnt[2];
`else
  assign flash_blank = 1'b0;
`endif

  // Final qualification of the ROM pixel: inside the box, armed, not keyed.
  always_comb begin
    opaque    = rom_data != COLOR_W'(KEY_COLOR);
    pix_valid = in_box_d2 && armed && opaque && !flash_blank;
    pix_color = pix_valid ? rom_data : '0;
  end

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Randomised bench for player_sprite_fetch with a frame-level reference
// model of the walk cycle, snapshot and sprite addressing, plus a small
// synchronous sprite ROM whose contents are a fixed function of address.
module tb_player_sprite_fetch;

  localparam int WALK_HOLD = 6;
  localparam int KEY       = 'hE3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       SCEN = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] anim_state = '0;
  logic [5:0] anim_frame = '0;
  logic       facing_left = 1'b0;
  logic [9:0] pos_x = '0;
  logic [9:0] pos_y = '0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       video_on = 1'b0;
  logic [14:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] pix_color;
  logic       pix_valid;

  int total = 0;
  int bad   = 0;

  int m_ticks, m_snap_state, m_snap_frame, m_snap_px, m_snap_py, m_cnt, p_addr;
  bit m_snap_facing, m_armed, p_inbox;

  always #5 clk = ~clk;

  player_sprite_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .SCEN        (SCEN),
    .frame_start (frame_start),
    .anim_state  (anim_state),
    .anim_frame  (anim_frame),
    .facing_left (facing_left),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .hcount      (hcount),
    .vcount      (vcount),
    .video_on    (video_on),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_color   (pix_color),
    .pix_valid   (pix_valid)
  );

  function automatic int romFn(input int a);
    if (a[3:0] == 4'd5) return KEY;
    return int'((a[7:0] ^ {1'b0, a[14:8]}) ^ 8'h1C);
  endfunction

  // Synchronous sprite ROM, one clock of read latency.
  always @(posedge clk) rom_data <= 8'(romFn(int'(rom_addr)));

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int st, input int fr, input int fl,
                               input int px, input int py, input int hc,
                               input int vc, input int von, input int fs,
                               input int sc);
    anim_state  = 4'(st);
    anim_frame  = 6'(fr);
    facing_left = fl[0];
    pos_x       = 10'(px);
    pos_y       = 10'(py);
    hcount      = 10'(hc);
    vcount      = 10'(vc);
    video_on    = von[0];
    frame_start = fs[0];
    SCEN        = sc[0];
  endtask

  function automatic void effOf(input int st, input int fr, input int widx,
                                output int es, output int ef);
    es = st;
    if (st > 6) begin es = 0; ef = 0; end
    else if (st == 1) ef = widx;
    else if (st == 5) ef = 0;
    else ef = (fr > 3) ? 3 : fr;
  endfunction

  // One clock: predict the outputs after the edge, advance the model, check.
  task automatic clockAndCheck();
    int widx, es, ef, col, row, mcol, addr_next, rd, color_next;
    bit inbox, arm_next, valid_next;
    widx  = (m_ticks / WALK_HOLD) % 4;
    col   = int'(hcount) - m_snap_px;
    row   = int'(vcount) - m_snap_py;
    inbox = video_on && col >= 0 && col < 32 && row >= 0 && row < 32;
    mcol  = m_snap_facing ? 31 - col : col;
    addr_next = inbox ? ((m_snap_state * 4 + m_snap_frame) * 32 + row) * 32 + mcol : 0;
    rd       = romFn(p_addr);
    arm_next = m_armed || frame_start;
    effOf(int'(anim_state), int'(anim_frame), widx, es, ef);
    if (frame_start) begin
      m_snap_state  = es;
      m_snap_frame  = ef;
      m_snap_px     = int'(pos_x);
      m_snap_py     = int'(pos_y);
      m_snap_facing = facing_left;
      m_cnt         = (m_cnt + 1) % 8;
    end
    if (SCEN) m_ticks = (anim_state == 4'd1) ? m_ticks + 1 : 0;
    m_armed    = arm_next;
    valid_next = p_inbox && arm_next && rd != KEY;
`ifdef HIT_FLASH_EN
    if (m_snap_state == 5 && m_cnt >= 4) valid_next = 1'b0;
`endif
    color_next = valid_next ? rd : 0;
    p_inbox = inbox;
    p_addr  = addr_next;
    @(posedge clk);
    #1;
    checkOutput("rom_addr", int'(rom_addr), addr_next);
    checkOutput("pix_valid", int'(pix_valid), int'(valid_next));
    checkOutput("pix_color", int'(pix_color), color_next);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_addr", int'(rom_addr), 0);
    checkOutput("rst_valid", int'(pix_valid), 0);
    checkOutput("rst_color", int'(pix_color), 0);
    repeat (3) @(posedge clk);
    #1;
    m_ticks = 0; m_snap_state = 0; m_snap_frame = 0; m_snap_px = 0;
    m_snap_py = 0; m_snap_facing = 0; m_armed = 0; m_cnt = 0;
    p_inbox = 0; p_addr = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    int st, px, py, hc, vc;
    #2;
    doReset();

    // Not armed yet: pixel over the sprite position must stay invisible.
    applyStimulus(0, 0, 0, 100, 50, 100, 50, 1, 0, 0);
    repeat (4) clockAndCheck();

    // IDLE snapshot, then opaque pixel at address 0 and keyed pixel at 5.
    applyStimulus(0, 0, 0, 100, 50, 0, 0, 0, 1, 0);
    clockAndCheck();
    applyStimulus(0, 0, 0, 100, 50, 100, 50, 1, 0, 0);
    clockAndCheck();
    checkOutput("idle_addr", int'(rom_addr), 0);
    applyStimulus(0, 0, 0, 100, 50, 105, 50, 1, 0, 0);
    clockAndCheck();
    checkOutput("idle_valid", int'(pix_valid), 1);
    checkOutput("idle_color", int'(pix_color), 'h1C);
    applyStimulus(0, 0, 0, 100, 50, 0, 0, 0, 0, 0);
    clockAndCheck();
    clockAndCheck();
    checkOutput("key_valid", int'(pix_valid), 0);

    // Walk cycle over 24 ticks, snapshotting every tick, then back to IDLE.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1, 0, 0, 100, 50, 100 + i, 50 + i, 1, 1, 1);
      clockAndCheck();
    end
    applyStimulus(0, 0, 0, 100, 50, 100, 50, 1, 1, 1);
    repeat (3) clockAndCheck();

    // ATK1 with out-of-range frame, mirrored.
    applyStimulus(3, 9, 1, 200, 100, 0, 0, 0, 1, 0);
    clockAndCheck();
    applyStimulus(3, 9, 1, 200, 100, 200, 100, 1, 0, 0);
    clockAndCheck();
    checkOutput("atk1_addr", int'(rom_addr), 15391);

    // Right-edge clipping: no wrap-around hits near hcount 0.
    applyStimulus(2, 1, 0, 630, 40, 0, 0, 0, 1, 0);
    clockAndCheck();
    for (int h = 620; h < 640; h++) begin
      applyStimulus(2, 1, 0, 630, 40, h, 43, 1, 0, 0);
      clockAndCheck();
    end
    for (int h = 0; h < 22; h++) begin
      applyStimulus(2, 1, 0, 630, 40, h, 43, 1, 0, 0);
      clockAndCheck();
    end

    // Random traffic with rare frame boundaries and one reset mid-frame.
    st = 0; px = 300; py = 200;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      if ($urandom_range(0, 19) == 0) begin
        st = ($urandom_range(0, 9) < 4) ? 1 : int'($urandom_range(0, 9));
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      hc = (m_snap_px + int'($urandom_range(0, 44)) - 6) & 1023;
      vc = (m_snap_py + int'($urandom_range(0, 44)) - 6) & 1023;
      applyStimulus(st, int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                    px, py, hc, vc, ($urandom_range(0, 9) != 0) ? 1 : 0,
                    ($urandom_range(0, 39) == 0) ? 1 : 0,
                    ($urandom_range(0, 2) == 0) ? 1 : 0);
      clockAndCheck();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_sprite_fetch.md
Name: player_sprite_fetch

Overview:
Consumer end of the player animation interface. Takes `anim_state`/`anim_frame` from the player state/animation block and turns them into sprite-ROM addresses and per-pixel colour for the VGA pixel pipeline.
- Snapshots the animation at each video frame start to avoid tearing.
- Generates a walk cycle internally, because the producer always sends frame 0 for WALK.
- Mirrors the sprite for facing and applies colour-key transparency.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 32, sprite height in pixels (power of 2)
- FRAMES_PER_STATE, 4, frames stored per animation state (power of 2)
- ADDR_W, 15, sprite ROM address width (7 states x 4 frames x 1024 px)
- COLOR_W, 8, pixel width (RGB332)
- KEY_COLOR, 8'hE3, transparent colour key
- WALK_HOLD, 6, SCEN ticks per walk-cycle frame

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- SCEN  in  1  game-tick strobe (same strobe as the animation producer)
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- anim_state  in  4  animation state from producer (IDLE=0, WALK=1, JUMP=2, ATK1=3, ATK2=4, HIT=5, LOSE=6)
- anim_frame  in  6  animation frame from producer
- facing_left  in  1  1 = mirror sprite horizontally
- pos_x  in  10  sprite top-left x
- pos_y  in  10  sprite top-left y
- hcount  in  10  current pixel x
- vcount  in  10  current pixel y
- video_on  in  1  active display region
- rom_addr  out  ADDR_W  sprite ROM address; synchronous ROM, 1-cycle read latency
- rom_data  in  COLOR_W  ROM read data
- pix_color  out  COLOR_W  sprite pixel colour
- pix_valid  out  1  sprite pixel is opaque and inside the box

Behaviour:
- Reset (async, reset_n=0): rom_addr=0, pix_color=0, pix_valid=0. Walk counter, hold counter, snapshot registers and armed flag all cleared.
- Armed flag: set on the first frame_start after reset. While clear, pix_valid=0.
- Walk sequencer, updated on SCEN:
  - If anim_state==WALK: hold counter counts 0..WALK_HOLD-1. On wrap, walk_idx increments mod FRAMES_PER_STATE.
  - If anim_state!=WALK: hold counter and walk_idx reset to 0.
- Effective frame:
  - WALK: walk_idx.
  - HIT: 0.
  - Other states: anim_frame saturated to FRAMES_PER_STATE-1 (e.g. 9 becomes 3).
  - anim_state>6: treated as IDLE, frame 0.
- Snapshot: on frame_start, latch the effective state, effective frame, pos_x, pos_y and facing_left.
  - If frame_start and SCEN coincide, the snapshot takes the pre-update walk_idx.
  - Between frame_start pulses, input changes have no visible effect.
- Pipeline, total latency 2 clocks from hcount/vcount to pix_color/pix_valid:
  - Stage 0 (combinational): col = hcount - px, row = vcount - py, computed 11-bit. in_box = video_on && 0<=col<SPR_W && 0<=row<SPR_H. Compare in 11 bits so px+SPR_W>=640 clips and does not wrap.
  - Stage 1 (registered): mcol = facing ? SPR_W-1-col : col. rom_addr = ((state*FRAMES_PER_STATE + frame)*SPR_H + row)*SPR_W + mcol, with all multiplies done as shifts. in_box_d1 registered. When not in_box, rom_addr=0.
  - Stage 2 (registered): pix_valid = in_box_d2 && armed && rom_data!=KEY_COLOR. pix_color = rom_data when pix_valid, else 0.
- Reset mid-frame: outputs drop to 0 immediately; nothing is drawn until the next frame_start.

Optional Feature:
- Macro: HIT_FLASH_EN.
- Defined:
  - A 3-bit frame_start counter runs continuously.
  - While the snapshot state is HIT, pix_valid is forced to 0 when counter bit 2 is 1, giving a 4-frame on / 4-frame off flash.
  - The counter resets with reset_n.
- Undefined: the HIT sprite draws normally and the counter logic is absent.

Decomposition:
- Shared package `anim_pkg`: S_IDLE..S_LOSE state encodings (4-bit), FRAMES_PER_STATE, SPR_W, SPR_H, KEY_COLOR. The producer and this block both import these.
- One sub-module, `anim_frame_seq`: walk hold counter, walk_idx, frame clamp and state sanitising. Outputs the effective state and frame.
- Box test, address pipeline and snapshot registers stay in the top module.

Test Plan:
1. reset_n low for 3 clocks, then anim_state=0, pos=(100,50), no frame_start → pix_valid stays 0; rom_addr=0.
2. IDLE, frame_start, then scan hcount=100,vcount=50 → rom_addr=0 appears 1 clock later; with rom_data=8'h1C, pix_valid=1 and pix_color=8'h1C 2 clocks after the pixel. Same scan with rom_data=8'hE3 → pix_valid=0.
3. anim_state=WALK for 24 SCEN ticks → walk_idx sequence 0,1,2,3,0, changing every 6 ticks. Switching to IDLE → walk_idx=0 on the next SCEN.
4. ATK1 with anim_frame=9, facing_left=1, frame_start, pixel (hcount=px, vcount=py) → rom_addr = ((3*4+3)*32+0)*32+31 = 15391.
5. pos_x=630 → pixels at hcount 630..639 give in_box=1. No wrap-around hit at hcount 0..21.
6. Change anim_state mid-frame → addresses unchanged until the next frame_start. With HIT_FLASH_EN and HIT: pix_valid is 0 on frames 4-7 of each 8.
